// File: rtl/rtc_multi_capture.sv
`timescale 1ns/1ps
// rtc_multi_capture: free-running time counter with per-channel edge capture,
// an Avalon-MM register file and a timed piezo burst sequencer.
// Optional feature macro: RTC_PRESCALER_EN (time_cnt ticks every PRESCALE
// clocks when defined, every clock otherwise).
//
// Burst FSM states:
//   state | meaning
//   IDLE  | piezo off, waiting for a start write with burst_cycles != 0
//   BURST | piezo on, down-counter running until it reaches 1 or an abort
module rtc_multi_capture #(
    parameter int NUM_CH   = 4,
    parameter int PRESCALE = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NUM_CH-1:0] event_trigger,
    input  logic [15:0]       avalon_slave_address,
    input  logic              avalon_slave_write,
    input  logic [31:0]       avalon_slave_writedata,
    input  logic              avalon_slave_read,
    output logic [31:0]       avalon_slave_readdata,
    output logic              avalon_slave_waitrequest,
    output logic              piezo_enable,
    output logic              capture_irq
);

    typedef enum logic {IDLE = 1'b0, BURST = 1'b1} burst_state_t;

    generate
        if (NUM_CH < 1 || NUM_CH > 16 || PRESCALE < 1) begin : g_bad_param
            $error("rtc_multi_capture: NUM_CH must be 1..16 and PRESCALE >= 1");
        end
    endgenerate

    logic [7:0]        page;
    logic              wr_time, wr_arm, wr_burst, wr_bcyc, wr_mask;
    logic              wr_start, wr_abort;
    logic              tick;
    logic [31:0]       time_cnt;
    logic [NUM_CH-1:0] sync_a, sync_b, sync_prev, edge_det;
    logic [NUM_CH-1:0] armed, captured, irq_mask, arm_bits;
    logic [31:0]       capture [NUM_CH];
    logic [31:0]       burst_cycles, burst_cnt, start_ts;
    burst_state_t      state;
    logic              wait_flag;
    logic [31:0]       rd_mux;
    logic              unused_addr_bits;

    assign page     = avalon_slave_address[15:8];
    assign wr_time  = avalon_slave_write && (page == 8'h00);
    assign wr_arm   = avalon_slave_write && (page == 8'h02);
    assign wr_burst = avalon_slave_write && (page == 8'h03);
    assign wr_bcyc  = avalon_slave_write && (page == 8'h04);
    assign wr_mask  = avalon_slave_write && (page == 8'h07);
    assign wr_start = wr_burst && (avalon_slave_writedata != 32'd0);
    assign wr_abort = wr_burst && (avalon_slave_writedata == 32'd0);
    assign arm_bits = avalon_slave_writedata[NUM_CH-1:0] & {NUM_CH{wr_arm}};
    assign unused_addr_bits = ^avalon_slave_address[7:0];

`ifdef RTC_PRESCALER_EN
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_RELOAD = PW'(PRESCALE - 1);
    logic [PW-1:0] presc_cnt;

    // Prescaler down-counter; the cleared state is a full period still to run.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            presc_cnt <= PRESC_RELOAD;
        else if (wr_time || presc_cnt == '0)
            presc_cnt <= PRESC_RELOAD;
        else
            presc_cnt <= presc_cnt - 1'b1;
    end

    assign tick = (presc_cnt == '0);
`else
    assign tick = 1'b1;
`endif

    // Time counter: a bus write wins over a same-cycle tick.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            time_cnt <= '0;
        else if (wr_time)
            time_cnt <= avalon_slave_writedata;
        else if (tick)
            time_cnt <= time_cnt + 32'd1;
    end

    // Two-flop synchroniser plus previous-value flop for rising-edge detection.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_a    <= '0;
            sync_b    <= '0;
            sync_prev <= '0;
        end else begin
            sync_a    <= event_trigger;
            sync_b    <= sync_a;
            sync_prev <= sync_b;
        end
    end

    assign edge_det = sync_b & ~sync_prev;

    // Per-channel arm/capture; an arm write masks a coincident edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            armed    <= '0;
            captured <= '0;
            for (int n = 0; n < NUM_CH; n++) capture[n] <= '0;
        end else begin
            for (int n = 0; n < NUM_CH; n++) begin
                if (arm_bits[n]) begin
                    armed[n]    <= 1'b1;
                    captured[n] <= 1'b0;
                end else if (edge_det[n] && armed[n]) begin
                    capture[n]  <= time_cnt;
                    armed[n]    <= 1'b0;
                    captured[n] <= 1'b1;
                end
            end
        end
    end

    // Plain configuration registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            irq_mask     <= '0;
            burst_cycles <= '0;
        end else begin
            if (wr_mask) irq_mask     <= avalon_slave_writedata[NUM_CH-1:0];
            if (wr_bcyc) burst_cycles <= avalon_slave_writedata;
        end
    end

    assign capture_irq = |(captured & irq_mask);

    // Burst sequencer; the down-counter is loaded only on entry, so later
    // burst_cycles writes do not disturb a running burst.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            burst_cnt    <= '0;
            start_ts     <= '0;
            piezo_enable <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (wr_start && burst_cycles != 32'd0) begin
                        state        <= BURST;
                        burst_cnt    <= burst_cycles;
                        start_ts     <= time_cnt;
                        piezo_enable <= 1'b1;
                    end
                end
                BURST: begin
                    if (wr_abort || burst_cnt == 32'd1) begin
                        state        <= IDLE;
                        piezo_enable <= 1'b0;
                    end else begin
                        burst_cnt <= burst_cnt - 32'd1;
                    end
                end
                default: begin
                    state        <= IDLE;
                    piezo_enable <= 1'b0;
                end
            endcase
        end
    end

    // Read decode; write-only and unmapped pages read back as 0xDEADBEEF.
    always_comb begin
        rd_mux = 32'hDEAD_BEEF;
        case (page)
            8'h00: rd_mux = time_cnt;
            8'h01: rd_mux = 32'(captured);
            8'h04: rd_mux = burst_cycles;
            8'h05: rd_mux = start_ts;
            8'h06: rd_mux = {16'(armed), 15'd0, (state == BURST)};
            8'h07: rd_mux = 32'(irq_mask);
            default: begin
                for (int n = 0; n < NUM_CH; n++)
                    if (page == 8'(8'h10 + n)) rd_mux = capture[n];
            end
        endcase
    end

    assign avalon_slave_waitrequest = avalon_slave_read && wait_flag;

    // One-wait-state read: register data while stalled, re-arm once read drops.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            avalon_slave_readdata <= '0;
            wait_flag             <= 1'b1;
        end else if (avalon_slave_read && wait_flag) begin
            avalon_slave_readdata <= rd_mux;
            wait_flag             <= 1'b0;
        end else if (!avalon_slave_read) begin
            wait_flag <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rtc_multi_capture.sv
`timescale 1ns/1ps
// Self-checking bench for rtc_multi_capture: read responses go through a
// scoreboard queue, expectations come from a cycle-indexed behavioural model.
module tb_rtc_multi_capture;

    localparam int NUM_CH   = 4;
    localparam int PRESCALE = 5;
`ifdef RTC_PRESCALER_EN
    localparam int P = PRESCALE;
`else
    localparam int P = 1;
`endif

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [NUM_CH-1:0] event_trigger = '0;
    logic [15:0]       avalon_slave_address = '0;
    logic              avalon_slave_write = 1'b0;
    logic [31:0]       avalon_slave_writedata = '0;
    logic              avalon_slave_read = 1'b0;
    logic [31:0]       avalon_slave_readdata;
    logic              avalon_slave_waitrequest;
    logic              piezo_enable;
    logic              capture_irq;

    rtc_multi_capture #(.NUM_CH(NUM_CH), .PRESCALE(PRESCALE)) dut (
        .clock                    (clock),
        .reset                    (reset),
        .event_trigger            (event_trigger),
        .avalon_slave_address     (avalon_slave_address),
        .avalon_slave_write       (avalon_slave_write),
        .avalon_slave_writedata   (avalon_slave_writedata),
        .avalon_slave_read        (avalon_slave_read),
        .avalon_slave_readdata    (avalon_slave_readdata),
        .avalon_slave_waitrequest (avalon_slave_waitrequest),
        .piezo_enable             (piezo_enable),
        .capture_irq              (capture_irq)
    );

    always #10 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc = cyc + 1;

    int tests = 0;
    int fails = 0;

    // Reference model state.
    logic [31:0] m_base;
    int          m_e;
    logic [3:0]  m_armed, m_captured, m_mask;
    logic [31:0] m_capture [NUM_CH];
    logic [31:0] m_bcyc;

    logic [31:0] exp_q[$];
    string       nm_q[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    // time_cnt as seen during cycle c: the value loaded at edge m_e plus one per P clocks.
    function automatic logic [31:0] m_time(input int c);
        return m_base + 32'((c - m_e) / P);
    endfunction

    function automatic logic [31:0] m_status();
        return {12'd0, m_armed, 15'd0, 1'b0};
    endfunction

    function automatic logic m_irq();
        return |(m_captured & m_mask);
    endfunction

    task automatic model_reset();
        m_base = '0;
        m_e = cyc;
        m_armed = '0;
        m_captured = '0;
        m_mask = '0;
        m_bcyc = '0;
        for (int n = 0; n < NUM_CH; n++) m_capture[n] = '0;
    endtask

    // Monitor: every completed read is compared against the oldest expectation.
    always @(negedge clock) begin
        if (avalon_slave_read && !avalon_slave_waitrequest) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_read: got 0x%08h, expected no response", avalon_slave_readdata);
            end else begin
                check(nm_q.pop_front(), avalon_slave_readdata, exp_q.pop_front());
            end
        end
    end

    task automatic bus_write(input logic [15:0] a, input logic [31:0] d);
        avalon_slave_address   = a;
        avalon_slave_writedata = d;
        avalon_slave_write     = 1'b1;
        case (a[15:8])
            8'h00: begin m_base = d; m_e = cyc + 1; end
            8'h02: begin m_armed = m_armed | d[3:0]; m_captured = m_captured & ~d[3:0]; end
            8'h04: m_bcyc = d;
            8'h07: m_mask = d[3:0];
            default: ;
        endcase
        @(negedge clock);
        avalon_slave_write = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] a, input logic [31:0] exp, input string nm,
                            output int waits);
        avalon_slave_address = a;
        avalon_slave_read    = 1'b1;
        exp_q.push_back(exp);
        nm_q.push_back(nm);
        waits = 0;
        forever begin
            @(negedge clock);
            waits++;
            if (!avalon_slave_waitrequest) break;
            if (waits > 20) begin
                tests++;
                fails++;
                $display("FAIL read_timeout: got waitrequest stuck, expected release");
                break;
            end
        end
        #1 avalon_slave_read = 1'b0;
        @(negedge clock);
    endtask

    task automatic rd(input logic [15:0] a, input logic [31:0] exp, input string nm);
        int w;
        bus_read(a, exp, nm, w);
    endtask

    // Pulse triggers; the armed-edge outcome lands two cycles after the drive.
    task automatic pulse(input logic [3:0] mask, output logic irq2, output logic irq3);
        int d;
        d = cyc;
        event_trigger = mask;
        for (int n = 0; n < NUM_CH; n++) begin
            if (mask[n] && m_armed[n]) begin
                m_capture[n]  = m_time(d + 2);
                m_captured[n] = 1'b1;
                m_armed[n]    = 1'b0;
            end
        end
        @(negedge clock);
        @(negedge clock);
        irq2 = capture_irq;
        @(negedge clock);
        irq3 = capture_irq;
        event_trigger = '0;
        repeat (3) @(negedge clock);
    endtask

    task automatic check_channels(input string tag);
        check({tag, "_irq"}, 32'(capture_irq), 32'(m_irq()));
        rd(16'h0100, 32'(m_captured), {tag, "_captured"});
        rd(16'h0600, m_status(), {tag, "_status"});
        for (int n = 0; n < NUM_CH; n++)
            rd(16'h1000 + 16'(n << 8), m_capture[n], $sformatf("%s_cap%0d", tag, n));
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got no finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          w, high, rises, d;
        logic        prev, i2, i3;
        logic [31:0] exp_ts;

        model_reset();
        repeat (3) @(negedge clock);
        check("rst_readdata", avalon_slave_readdata, 32'd0);
        check("rst_piezo", 32'(piezo_enable), 32'd0);
        check("rst_irq", 32'(capture_irq), 32'd0);
        reset = 1'b0;
        model_reset();

        // Back-to-back time reads: one wait state each, values from the model.
        bus_read(16'h0000, m_time(cyc), "time_rd1", w);
        check("wait_states1", 32'(w), 32'd1);
        bus_read(16'h0000, m_time(cyc), "time_rd2", w);
        check("wait_states2", 32'(w), 32'd1);

        // Wrap: two ticks after writing 0xFFFFFFFE the counter reads zero.
        bus_write(16'h0000, 32'hFFFF_FFFE);
        repeat (2 * P - 1) @(negedge clock);
        rd(16'h0000, 32'hFFFF_FFFF, "wrap_pre");
        bus_write(16'h0000, 32'hFFFF_FFFE);
        repeat (2 * P) @(negedge clock);
        rd(16'h0000, 32'h0000_0000, "wrap_zero");
        rd(16'h0000, m_time(cyc), "wrap_post");

        // Simultaneous capture on channels 0 and 2 with a 3-clock flag latency.
        bus_write(16'h0700, 32'h5);
        bus_write(16'h0200, 32'h5);
        pulse(4'h5, i2, i3);
        check("latency_2clk", 32'(i2), 32'd0);
        check("latency_3clk", 32'(i3), 32'd1);
        check_channels("dual");
        pulse(4'h5, i2, i3);
        check_channels("dual_again");

        // Arm write coinciding with a detected edge on channel 3.
        d = cyc;
        event_trigger = 4'h8;
        @(negedge clock);
        @(negedge clock);
        bus_write(16'h0200, 32'h8);
        event_trigger = '0;
        repeat (3) @(negedge clock);
        check_channels("arm_edge");
        pulse(4'h8, i2, i3);
        check_channels("arm_edge_next");

        // irq masking, re-arm clears, unmapped and out-of-range reads.
        bus_write(16'h0700, 32'h2);
        bus_write(16'h0200, 32'h3);
        pulse(4'h2, i2, i3);
        check("irq_set", 32'(capture_irq), 32'd1);
        bus_write(16'h0200, 32'h2);
        check("irq_clr", 32'(capture_irq), 32'd0);
        rd(16'h1F00, 32'hDEAD_BEEF, "unmapped_1f");
        rd(16'h1400, 32'hDEAD_BEEF, "chan_oob");
        bus_write(16'h1400, 32'h1234_5678);
        rd(16'h0700, 32'(m_mask), "irq_mask_rd");

        // Randomised arm / trigger / time-write mix.
        for (int it = 0; it < 10; it++) begin
            if ($urandom_range(3, 0) == 0) bus_write(16'h0000, $urandom);
            if ($urandom_range(1, 0) == 1) bus_write(16'h0700, 32'($urandom_range(15, 0)));
            bus_write(16'h0200, 32'($urandom_range(15, 1)));
            repeat ($urandom_range(4, 0)) @(negedge clock);
            pulse(4'($urandom_range(15, 0)), i2, i3);
            check_channels($sformatf("rnd%0d", it));
        end

        // Burst of 10 with an ignored restart and a burst_cycles rewrite mid-burst.
        bus_write(16'h0400, 32'd10);
        check("piezo_idle", 32'(piezo_enable), 32'd0);
        exp_ts = m_time(cyc);
        avalon_slave_address = 16'h0300; avalon_slave_writedata = 32'd1; avalon_slave_write = 1'b1;
        high = 0; rises = 0; prev = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            avalon_slave_write = 1'b0;
            if (i == 4) begin
                avalon_slave_address = 16'h0300; avalon_slave_writedata = 32'd1; avalon_slave_write = 1'b1;
            end
            if (i == 6) begin
                avalon_slave_address = 16'h0400; avalon_slave_writedata = 32'd50; avalon_slave_write = 1'b1;
                m_bcyc = 32'd50;
            end
            if (i == 0) check("piezo_rise", 32'(piezo_enable), 32'd1);
            if (piezo_enable) high++;
            if (piezo_enable && !prev) rises++;
            prev = piezo_enable;
        end
        check("burst_len", 32'(high), 32'd10);
        check("burst_rises", 32'(rises), 32'd1);
        rd(16'h0500, exp_ts, "start_ts");
        rd(16'h0400, m_bcyc, "burst_cycles_rd");

        // Abort after 20 clocks of a 100-clock burst.
        bus_write(16'h0400, 32'd100);
        avalon_slave_address = 16'h0300; avalon_slave_writedata = 32'd1; avalon_slave_write = 1'b1;
        high = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            avalon_slave_write = 1'b0;
            if (i == 19) begin
                avalon_slave_address = 16'h0300; avalon_slave_writedata = 32'd0; avalon_slave_write = 1'b1;
            end
            if (i == 20) check("abort_drop", 32'(piezo_enable), 32'd0);
            if (piezo_enable) high++;
        end
        check("abort_len", 32'(high), 32'd20);
        rd(16'h0600, m_status(), "abort_status");

        // Start with burst_cycles == 0 is ignored.
        bus_write(16'h0400, 32'd0);
        bus_write(16'h0300, 32'd1);
        high = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            if (piezo_enable) high++;
        end
        check("zero_burst", 32'(high), 32'd0);

        // Reset asserted mid-burst drops piezo immediately and clears state.
        bus_write(16'h0400, 32'd100);
        bus_write(16'h0300, 32'd1);
        repeat (3) @(negedge clock);
        check("pre_reset_piezo", 32'(piezo_enable), 32'd1);
        #2 reset = 1'b1;
        #1 check("reset_piezo", 32'(piezo_enable), 32'd0);
        check("reset_irq", 32'(capture_irq), 32'd0);
        check("reset_readdata", avalon_slave_readdata, 32'd0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        rd(16'h0000, m_time(cyc), "post_reset_time");
        rd(16'h0400, 32'd0, "post_reset_bcyc");
        check_channels("post_reset");

        repeat (2) @(negedge clock);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
